// File: rtl/ro_sweep_scheduler_if.sv
// Control/result bundle between the AXI-Lite register slave (master side)
// and the ring-oscillator sweep scheduler (slave side).
interface ro_sweep_scheduler_if #(
    parameter int N_RO  = 4,
    parameter int CNT_W = 24,
    parameter int SET_W = 16,
    parameter int WIN_W = 24
);
    localparam int SEL_W = $clog2(N_RO);

    logic             start;
    logic             abort;
    logic             continuous;
    logic [N_RO-1:0]  mask;
    logic [SET_W-1:0] settle_cycles;
    logic [WIN_W-1:0] window_cycles;
    logic             busy;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] result_data;
    logic [SEL_W-1:0] result_idx;
    logic             result_valid;
    logic             sweep_done;
    logic             overflow;

    modport master (
        output start, abort, continuous, mask, settle_cycles, window_cycles,
        input  busy, sel, result_data, result_idx, result_valid, sweep_done, overflow
    );

    modport slave (
        input  start, abort, continuous, mask, settle_cycles, window_cycles,
        output busy, sel, result_data, result_idx, result_valid, sweep_done, overflow
    );
endinterface

// File: rtl/ro_sweep_scheduler.sv
// Round-robin ring-oscillator frequency sweep: settle, gated edge count, publish.
// Optional macro RO_SWEEP_STRESS_EN keeps masked ROs enabled outside measurement for BTI stress.
module ro_sweep_scheduler #(
    parameter int N_RO  = 4,
    parameter int CNT_W = 24,
    parameter int SET_W = 16,
    parameter int WIN_W = 24
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    ro_sweep_scheduler_if.slave   bus,
    input  logic [N_RO-1:0]       ro_div,
    output logic [N_RO-1:0]       ro_en
);
    localparam int SEL_W = $clog2(N_RO);
    localparam int TMR_W = (SET_W > WIN_W) ? SET_W : WIN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        SETTLE,
        GATE,
        STORE
    } state_t;

    state_t           state_reg;
    logic [N_RO-1:0]  mask_reg;
    logic [SET_W-1:0] settle_reg;
    logic [WIN_W-1:0] window_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [N_RO-1:0]  ro_en_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] result_data_reg;
    logic [SEL_W-1:0] result_idx_reg;
    logic             result_valid_reg;
    logic             sweep_done_reg;
    logic             overflow_reg;

    logic [N_RO-1:0]  edge_vec;
    logic             edge_hit;
    logic [SEL_W-1:0] pick_idx;
    logic             more_left;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_hit;
    logic [TMR_W-1:0] settle_m1;
    logic [TMR_W-1:0] window_m1;

    // Every RO bit is synchronized all the time so a change of sel never
    // exposes a stale history bit as a fake rising edge.
    genvar gi;
    generate
        for (gi = 0; gi < N_RO; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;
            logic hist_reg;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    hist_reg  <= 1'b0;
                end else begin
                    sync1_reg <= ro_div[gi];
                    sync2_reg <= sync1_reg;
                    hist_reg  <= sync2_reg;
                end
            end

            assign edge_vec[gi] = sync2_reg & ~hist_reg;
        end
    endgenerate

    assign edge_hit = edge_vec[sel_reg];

    // Lowest masked index at or above the pointer.
    always_comb begin
        pick_idx = '0;
        for (int i = N_RO - 1; i >= 0; i--) begin
            if (mask_reg[i] && (SEL_W'(i) >= ptr_reg)) begin
                pick_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        more_left = 1'b0;
        for (int i = 0; i < N_RO; i++) begin
            if (mask_reg[i] && (SEL_W'(i) > sel_reg)) begin
                more_left = 1'b1;
            end
        end
    end

    // Saturating count; an edge arriving at full scale is lost and flagged.
    always_comb begin
        cnt_next = cnt_reg;
        sat_hit  = 1'b0;
        if (edge_hit) begin
            if (cnt_reg == CNT_MAX) begin
                sat_hit = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // Timers count down to zero, so a zero length behaves like one cycle.
    assign settle_m1 = (settle_reg == '0) ? '0 : TMR_W'(settle_reg) - TMR_W'(1);
    assign window_m1 = (window_reg == '0) ? '0 : TMR_W'(window_reg) - TMR_W'(1);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg        <= IDLE;
            mask_reg         <= '0;
            settle_reg       <= '0;
            window_reg       <= '0;
            ptr_reg          <= '0;
            sel_reg          <= '0;
            timer_reg        <= '0;
            cnt_reg          <= '0;
            ro_en_reg        <= '0;
            busy_reg         <= 1'b0;
            result_data_reg  <= '0;
            result_idx_reg   <= '0;
            result_valid_reg <= 1'b0;
            sweep_done_reg   <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            sweep_done_reg   <= 1'b0;

            if (bus.abort && (state_reg != IDLE)) begin
                state_reg <= IDLE;
                ro_en_reg <= '0;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start && !bus.abort && (bus.mask != '0)) begin
                            mask_reg     <= bus.mask;
                            settle_reg   <= bus.settle_cycles;
                            window_reg   <= bus.window_cycles;
                            overflow_reg <= 1'b0;
                            ptr_reg      <= '0;
                            busy_reg     <= 1'b1;
                            state_reg    <= PICK;
                        end
                    end

                    PICK: begin
                        sel_reg   <= pick_idx;
                        cnt_reg   <= '0;
                        timer_reg <= settle_m1;
                        ro_en_reg <= N_RO'(1) << pick_idx;
                        state_reg <= SETTLE;
                    end

                    SETTLE: begin
                        if (timer_reg == '0) begin
                            timer_reg <= window_m1;
                            state_reg <= GATE;
                        end else begin
                            timer_reg <= timer_reg - TMR_W'(1);
                        end
                    end

                    GATE: begin
                        cnt_reg <= cnt_next;
                        if (sat_hit) begin
                            overflow_reg <= 1'b1;
                        end
                        if (timer_reg == '0) begin
                            result_data_reg  <= cnt_next;
                            result_idx_reg   <= sel_reg;
                            result_valid_reg <= 1'b1;
                            sweep_done_reg   <= ~more_left;
                            ro_en_reg        <= '0;
                            state_reg        <= STORE;
                        end else begin
                            timer_reg <= timer_reg - TMR_W'(1);
                        end
                    end

                    STORE: begin
                        ptr_reg <= sel_reg + SEL_W'(1);
                        if (more_left) begin
                            state_reg <= PICK;
                        end else if (bus.continuous) begin
                            mask_reg   <= bus.mask;
                            settle_reg <= bus.settle_cycles;
                            window_reg <= bus.window_cycles;
                            ptr_reg    <= '0;
                            if (bus.mask == '0) begin
                                busy_reg  <= 1'b0;
                                state_reg <= IDLE;
                            end else begin
                                state_reg <= PICK;
                            end
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end

                    default: begin
                        ro_en_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef RO_SWEEP_STRESS_EN
    // Measured RO alone during SETTLE/GATE; otherwise the whole latched mask is stressed.
    always_comb begin
        ro_en = '0;
        if ((state_reg == SETTLE) || (state_reg == GATE)) begin
            ro_en = ro_en_reg;
        end else if (busy_reg || bus.continuous) begin
            ro_en = mask_reg;
        end
    end
`else
    assign ro_en = ro_en_reg;
`endif

    assign bus.busy         = busy_reg;
    assign bus.sel          = sel_reg;
    assign bus.result_data  = result_data_reg;
    assign bus.result_idx   = result_idx_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.sweep_done   = sweep_done_reg;
    assign bus.overflow     = overflow_reg;

endmodule

// File: tb/tb_ro_sweep_scheduler.sv
// Directed bench for ro_sweep_scheduler: a 24-bit counter instance for sweep,
// abort, continuous and reset cases, plus a 2-bit counter instance for saturation.
module tb_ro_sweep_scheduler;
    localparam int N_RO = 4;

    logic            ACLK    = 1'b0;
    logic            ARESETN = 1'b0;
    logic [N_RO-1:0] ro_div  = '0;
    logic [N_RO-1:0] ro_en;
    logic [N_RO-1:0] ro_en2;

    int per [N_RO] = '{default: 0};
    int pc  [N_RO] = '{default: 0};

    int checks = 0;
    int errors = 0;

    ro_sweep_scheduler_if #(.N_RO(N_RO), .CNT_W(24), .SET_W(16), .WIN_W(24)) bus ();
    ro_sweep_scheduler_if #(.N_RO(N_RO), .CNT_W(2),  .SET_W(16), .WIN_W(24)) bus2 ();

    ro_sweep_scheduler #(.N_RO(N_RO), .CNT_W(24), .SET_W(16), .WIN_W(24)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus),
        .ro_div  (ro_div),
        .ro_en   (ro_en)
    );

    ro_sweep_scheduler #(.N_RO(N_RO), .CNT_W(2), .SET_W(16), .WIN_W(24)) dut2 (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus2),
        .ro_div  (ro_div),
        .ro_en   (ro_en2)
    );

    always #5 ACLK = ~ACLK;

    // Divided-RO waveforms: per[i] cycles per period, 50% duty, 0 = held low.
    always @(negedge ACLK) begin
        for (int i = 0; i < N_RO; i++) begin
            if (per[i] == 0) begin
                ro_div[i] = 1'b0;
                pc[i] = 0;
            end else begin
                ro_div[i] = (pc[i] < per[i] / 2);
                pc[i] = (pc[i] + 1 >= per[i]) ? 0 : pc[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n_valid, n_done, t_v1, t_v2, t_done, t_idle, t_first, n_act;
        logic [31:0] d1, d2, i1, i2, ovf_at_done;

        bus.start = 0;  bus.abort = 0;  bus.continuous = 0;
        bus.mask = '0;  bus.settle_cycles = '0;  bus.window_cycles = '0;
        bus2.start = 0; bus2.abort = 0; bus2.continuous = 0;
        bus2.mask = '0; bus2.settle_cycles = '0; bus2.window_cycles = '0;

        // Reset state
        #1;
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_ro_en",  32'(ro_en), 0);
        chk("rst_sel",    32'(bus.sel), 0);
        chk("rst_data",   32'(bus.result_data), 0);
        chk("rst_idx",    32'(bus.result_idx), 0);
        chk("rst_valid",  32'(bus.result_valid), 0);
        chk("rst_done",   32'(bus.sweep_done), 0);
        chk("rst_ovf",    32'(bus.overflow), 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Two-RO sweep: mask 1010, S=4, W=100
        per[1] = 8;
        per[3] = 10;
        bus.mask = 4'b1010;
        bus.settle_cycles = 4;
        bus.window_cycles = 100;
        repeat (20) @(negedge ACLK);
        bus.start = 1;
        n_valid = 0; n_done = 0; t_v1 = 0; t_v2 = 0; t_done = 0; t_idle = 0;
        d1 = 0; d2 = 0; i1 = 0; i2 = 0;
        for (int t = 1; t <= 230; t++) begin
            @(negedge ACLK);
            bus.start = 0;
            if (t == 1) begin
                chk("sw_busy_c1", 32'(bus.busy), 1);
                chk("sw_pick_en", 32'(ro_en), 0);
            end
            if (t == 2) begin
                chk("sw_sel1", 32'(bus.sel), 1);
                chk("sw_en1", 32'(ro_en), 32'b0010);
            end
            if (t == 108) chk("sw_en3", 32'(ro_en), 32'b1000);
            if (bus.result_valid) begin
                n_valid++;
                if (n_valid == 1) begin
                    t_v1 = t; d1 = 32'(bus.result_data); i1 = 32'(bus.result_idx);
                end else begin
                    t_v2 = t; d2 = 32'(bus.result_data); i2 = 32'(bus.result_idx);
                end
            end
            if (bus.sweep_done) begin
                n_done++;
                t_done = t;
            end
            if (!bus.busy && t_idle == 0) t_idle = t;
            if (t == 50) begin
                bus.mask = 4'b1111;
                bus.window_cycles = 7;
            end
        end
        chk("sw_nvalid", n_valid, 2);
        chk("sw_t1", t_v1, 106);
        chk("sw_idx1", i1, 1);
        chk("sw_data1_12_13", 32'((d1 == 12) || (d1 == 13)), 1);
        chk("sw_t2", t_v2, 212);
        chk("sw_idx2", i2, 3);
        chk("sw_data2", d2, 10);
        chk("sw_ndone", n_done, 1);
        chk("sw_tdone", t_done, 212);
        chk("sw_tidle", t_idle, 213);
        chk("sw_ovf", 32'(bus.overflow), 0);
        per[1] = 0;
        per[3] = 0;

        // Saturation on the 2-bit instance: W=16, period 4 -> 4 edges
        per[0] = 4;
        bus2.mask = 4'b0001;
        bus2.settle_cycles = 4;
        bus2.window_cycles = 16;
        repeat (8) @(negedge ACLK);
        bus2.start = 1;
        t_done = 0; d1 = 0; ovf_at_done = 0;
        for (int t = 1; t <= 60; t++) begin
            @(negedge ACLK);
            bus2.start = 0;
            if (t == 10) chk("ov_en2", 32'(ro_en2), 32'b0001);
            if (bus2.sweep_done && t_done == 0) begin
                t_done = t;
                d1 = 32'(bus2.result_data);
                ovf_at_done = 32'(bus2.overflow);
            end
        end
        chk("ov_tdone", t_done, 22);
        chk("ov_data", d1, 3);
        chk("ov_flag", ovf_at_done, 1);
        chk("ov_sticky", 32'(bus2.overflow), 1);
        per[0] = 0;
        repeat (6) @(negedge ACLK);
        bus2.start = 1;
        @(negedge ACLK);
        bus2.start = 0;
        chk("ov_clr", 32'(bus2.overflow), 0);
        chk("ov_busy2", 32'(bus2.busy), 1);
        t_done = 0; d1 = 32'hFFFF;
        for (int t = 2; t <= 60; t++) begin
            @(negedge ACLK);
            if (bus2.sweep_done && t_done == 0) begin
                t_done = t;
                d1 = 32'(bus2.result_data);
            end
        end
        chk("ov_tdone2", t_done, 22);
        chk("ov_data0", d1, 0);
        chk("ov_flag0", 32'(bus2.overflow), 0);

        // Abort during GATE of idx 2
        per[2] = 6;
        bus.mask = 4'b0100;
        bus.settle_cycles = 2;
        bus.window_cycles = 50;
        repeat (6) @(negedge ACLK);
        bus.start = 1;
        n_valid = 0; n_done = 0;
        for (int t = 1; t <= 80; t++) begin
            @(negedge ACLK);
            bus.start = 0;
            bus.abort = 0;
            if (bus.result_valid) n_valid++;
            if (bus.sweep_done) n_done++;
            if (t == 21) begin
                chk("ab_busy", 32'(bus.busy), 0);
                chk("ab_en", 32'(ro_en), 0);
            end
            if (t == 20) begin
                chk("ab_en_gate", 32'(ro_en), 32'b0100);
                chk("ab_sel", 32'(bus.sel), 2);
                bus.abort = 1;
            end
        end
        chk("ab_nvalid", n_valid, 0);
        chk("ab_ndone", n_done, 0);
        chk("ab_data", 32'(bus.result_data), 10);
        chk("ab_idx", 32'(bus.result_idx), 3);
        per[2] = 0;

        // Continuous mode, mask 0001, S=3, W=5 -> period 10; mask cleared mid third sweep
        per[0] = 4;
        bus.mask = 4'b0001;
        bus.settle_cycles = 3;
        bus.window_cycles = 5;
        bus.continuous = 1;
        repeat (6) @(negedge ACLK);
        bus.start = 1;
        n_done = 0; t_first = 0; t_done = 0;
        for (int t = 1; t <= 45; t++) begin
            @(negedge ACLK);
            bus.start = 0;
            if (bus.sweep_done) begin
                n_done++;
                if (t_first == 0) t_first = t;
                t_done = t;
            end
            if (t == 27) chk("ct_en_mid", 32'(ro_en), 32'b0001);
            if (t == 31) chk("ct_idle", 32'(bus.busy), 0);
            if (t == 25) bus.mask = 4'b0000;
        end
        chk("ct_ndone", n_done, 3);
        chk("ct_first", t_first, 10);
        chk("ct_last", t_done, 30);
        chk("ct_data_nz", 32'(bus.result_data != 0), 1);
        bus.continuous = 0;
        per[0] = 0;

        // Reset asserted during SETTLE
        bus.mask = 4'b0010;
        bus.settle_cycles = 10;
        bus.window_cycles = 10;
        bus.start = 1;
        @(negedge ACLK);
        bus.start = 0;
        repeat (3) @(negedge ACLK);
        chk("rs_en_pre", 32'(ro_en), 32'b0010);
        #1 ARESETN = 1'b0;
        #1;
        chk("rs_busy", 32'(bus.busy), 0);
        chk("rs_en", 32'(ro_en), 0);
        chk("rs_sel", 32'(bus.sel), 0);
        chk("rs_data", 32'(bus.result_data), 0);
        chk("rs_idx", 32'(bus.result_idx), 0);
        chk("rs_valid", 32'(bus.result_valid), 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        n_act = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge ACLK);
            if (bus.busy || (ro_en != 0) || bus.result_valid || bus.sweep_done) n_act++;
        end
        chk("rs_quiet", n_act, 0);

        // start ignored with mask 0, and dropped when abort is coincident
        bus.mask = 4'b0000;
        bus.start = 1;
        @(negedge ACLK);
        bus.start = 0;
        chk("ig_mask0", 32'(bus.busy), 0);
        @(negedge ACLK);
        chk("ig_mask0_b", 32'(bus.busy), 0);
        bus.mask = 4'b0001;
        bus.start = 1;
        bus.abort = 1;
        @(negedge ACLK);
        bus.start = 0;
        bus.abort = 0;
        chk("ig_abort", 32'(bus.busy), 0);
        @(negedge ACLK);
        chk("ig_abort_b", 32'(bus.busy), 0);
        chk("ig_abort_en", 32'(ro_en), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ro_sweep_scheduler.md
# ro_sweep_scheduler

Measurement scheduler for the BTI ring-oscillator sensor bank. It shares one frequency-count datapath among `N_RO` ring oscillators in round-robin order. For each oscillator it enables it, waits a settle interval, counts divided-RO rising edges over a fixed gate window of `ACLK` cycles, and publishes the count with its index. It sits between the AXI-Lite register slave, which supplies config/start and reads results, and the RO macro array.

## Interface
- `N_RO`, 4: number of ring oscillators, 2..16.
- `CNT_W`, 24: edge-counter and result width.
- `SET_W`, 16: settle-interval register width.
- `WIN_W`, 24: gate-window register width.

- `ACLK`  in  1  sole clock; all logic is on its rising edge.
- `ARESETN`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep.
- `abort`  in  1  one-cycle request to stop the sweep.
- `continuous`  in  1  level input; when 1, the sweep restarts after each sweep_done.
- `mask`  in  N_RO  1 marks an oscillator as included in the sweep.
- `settle_cycles`  in  SET_W  settle length, S.
- `window_cycles`  in  WIN_W  gate length, W.
- `ro_div`  in  N_RO  divided RO outputs; asynchronous; each below ACLK/4.
- `ro_en`  out  N_RO  per-RO enable.
- `busy`  out  1  1 in any state except IDLE.
- `sel`  out  clog2(N_RO)  index currently being measured.
- `result_data`  out  CNT_W  last captured count.
- `result_idx`  out  clog2(N_RO)  index belonging to result_data.
- `result_valid`  out  1  one-cycle pulse when a new result is published.
- `sweep_done`  out  1  one-cycle pulse after the last masked RO is stored.
- `overflow`  out  1  sticky flag: some count saturated during this sweep.

## Operation
- Each `ro_div` bit passes through its own 2-flop synchronizer and a history flop. All bits are synchronized in parallel, so switching `sel` never creates a false edge.
- Edge event = synchronized bit is 1 and its history bit is 0, for the selected index.
- FSM states: IDLE, PICK, SETTLE, GATE, STORE.
- IDLE: `start` = 1 and latched-to-be `mask` ≠ 0 → latch mask, S, W; clear `overflow`; pointer = 0; go to PICK. If `mask` = 0, `start` is ignored.
- PICK: `sel` = lowest set bit of the latched mask with index ≥ pointer; clear the counter; go to SETTLE.
- SETTLE: `ro_en[sel]` = 1; wait max(S,1) cycles; go to GATE.
- GATE: `ro_en[sel]` = 1; count edge events for max(W,1) cycles. The counter saturates at 2^CNT_W−1 and sets `overflow`. Then go to STORE.
- STORE: `result_data` ← count, `result_idx` ← `sel`, pulse `result_valid`; pointer ← `sel`+1.
  - If a higher masked index remains → PICK.
  - Otherwise pulse `sweep_done` in the same cycle. If `continuous` = 1 → pointer = 0 and go to PICK, re-latching `mask`, S, W first; if the new mask = 0 go to IDLE instead. If `continuous` = 0 → IDLE.
- `abort` in any non-IDLE state → IDLE on the next edge. No `result_valid` or `sweep_done`; `ro_en` = 0; `result_*` keep their old values.
- `abort` and `start` together in IDLE: `abort` wins and `start` is dropped.
- `start` while busy is ignored.
- Config inputs are read only at sweep start; changes mid-sweep have no effect.

## Timing
- Reset values: state = IDLE; `ro_en` = 0, `busy` = 0, `sel` = 0, `result_data` = 0, `result_idx` = 0, `result_valid` = 0, `sweep_done` = 0, `overflow` = 0; synchronizers = 0.
- Reset asserted mid-sweep clears everything immediately, asynchronously. The first action after release requires a fresh `start`.
- `start` sampled in cycle 0 → PICK in cycle 1, `busy` = 1 from cycle 1. Per RO, PICK→STORE spans max(S,1) + max(W,1) + 2 cycles; a sweep of k ROs takes k times that.
- `ro_en[sel]` is 1 exactly during SETTLE and GATE (stress macro below aside); one-hot or zero.
- Edge count latency: a `ro_div` rise is counted 3 cycles later, in the cycle its edge event is detected, if that cycle is in GATE.
- `result_valid` and `sweep_done` are high for one cycle in STORE. `result_data` and `result_idx` are stable until the next STORE.

## Configuration
- `RO_SWEEP_STRESS_EN` defined: outside SETTLE/GATE, while `busy`, all masked ROs are held enabled (BTI stress). During SETTLE/GATE only `sel` is enabled. In IDLE, `ro_en` = latched mask if `continuous` = 1, else 0.
- Undefined: `ro_en` is strictly as in Operation; all other bits are 0.

## Test plan
- Reset; mask = 4'b1010, S = 4, W = 100; `ro_div[1]` period 8, `ro_div[3]` period 10, `start` → `result_valid` with idx 1, data 12 or 13; then idx 3, data 10; `sweep_done` on the second STORE; 2×106 = 212 cycles total.
- W = 16, `ro_div[0]` period 4, CNT_W overridden to 2 → data = 3, `overflow` = 1; next `start` clears `overflow`.
- `abort` asserted during GATE of idx 2 → IDLE next cycle, `ro_en` = 0, no `result_valid`, `result_data` unchanged.
- `continuous` = 1, mask = 4'b0001 → `sweep_done` every 1·(S+W+2) cycles; change mask to 0 mid-sweep → returns to IDLE after that sweep's `sweep_done`.
- `ARESETN` low during SETTLE → all outputs 0 within the same cycle; after release, no activity without `start`.
- `start` with mask = 0, and `start` together with `abort` → `busy` stays 0.
